// File: rtl/pktmem_rd_arbiter_pkg.sv
// Shared packet-memory read arbiter defaults: address width, read latency and BPF transfer-size codes.
// Also provides the id-width helper used to size per-core tags.
package pktmem_rd_arbiter_pkg;

    localparam int PKTMEM_ADDR_W = 10;
    localparam int PKTMEM_DATA_W = 32;
    localparam int PKTMEM_RD_LAT = 1;

    // Size field of a BPF load opcode (bits [4:3]); carried to memory untouched.
    typedef enum logic [1:0] {
        BPF_W  = 2'b00,
        BPF_H  = 2'b01,
        BPF_B  = 2'b10,
        BPF_DW = 2'b11
    } bpf_size_e;

    function automatic int cpu_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pktmem_rd_arbiter_rr_prio_enc.sv
// Combinational round-robin priority encoder: picks the first eligible index at or after prio_ptr.
// Produces a one-hot grant, its binary id and an any-grant flag.
module rr_prio_enc #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   eligible,
    input  logic [IDW-1:0] prio_ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] id,
    output logic           any
);

    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_w;
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(prio_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = IDW'(idx);
            if (!any && eligible[idx_w]) begin
                any          = 1'b1;
                grant[idx_w] = 1'b1;
                id           = idx_w;
            end
        end
    end

endmodule

// File: rtl/pktmem_rd_arbiter.sv
// Round-robin arbiter sharing one packet-memory read port among N_CPUS cores, with cancellable tag pipe.
// Optional per-core grant and conflict counters are built when PKTMEM_ARB_STATS_EN is defined.
module pktmem_rd_arbiter
    import pktmem_rd_arbiter_pkg::*;
#(
    parameter int N_CPUS = 4,
    parameter int ADDR_W = PKTMEM_ADDR_W,
    parameter int DATA_W = PKTMEM_DATA_W,
    parameter int RD_LAT = PKTMEM_RD_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CPUS-1:0]        rd_req,
    input  logic [N_CPUS*ADDR_W-1:0] rd_addr,
    input  logic [N_CPUS*2-1:0]      rd_sz,
    input  logic [N_CPUS-1:0]        cancel,
    output logic [N_CPUS-1:0]        rd_ack,
    output logic [N_CPUS-1:0]        rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    output logic [1:0]               mem_rd_sz,
`ifdef PKTMEM_ARB_STATS_EN
    output logic [N_CPUS*16-1:0]     stat_grants,
    output logic [15:0]              stat_conflicts,
`endif
    input  logic [DATA_W-1:0]        mem_rd_data
);

    localparam int IDW  = cpu_id_w(N_CPUS);
    localparam int NSTG = RD_LAT + 1;

    logic [N_CPUS-1:0] eligible;
    logic [N_CPUS-1:0] grant;
    logic [IDW-1:0]    grant_id;
    logic              grant_any;
    logic [IDW-1:0]    prio_ptr_reg;
    logic [IDW-1:0]    prio_ptr_next;

    logic [NSTG-1:0]   tag_v_reg;
    logic [IDW-1:0]    tag_id_reg [NSTG];
    logic [NSTG-1:0]   tag_live;

    assign eligible = rd_req & ~cancel;

    rr_prio_enc #(
        .N   (N_CPUS),
        .IDW (IDW)
    ) u_prio_enc (
        .eligible (eligible),
        .prio_ptr (prio_ptr_reg),
        .grant    (grant),
        .id       (grant_id),
        .any      (grant_any)
    );

    assign rd_ack = rst ? '0 : grant;

    always_comb begin
        prio_ptr_next = prio_ptr_reg;
        if (grant_any) begin
            prio_ptr_next = (grant_id == IDW'(N_CPUS - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_ptr_reg <= '0;
            mem_rd_en    <= 1'b0;
            mem_rd_addr  <= '0;
            mem_rd_sz    <= '0;
        end else begin
            prio_ptr_reg <= prio_ptr_next;
            mem_rd_en    <= grant_any;
            if (grant_any) begin
                mem_rd_addr <= rd_addr[int'(grant_id)*ADDR_W +: ADDR_W];
                mem_rd_sz   <= rd_sz[int'(grant_id)*2 +: 2];
            end
        end
    end

    // A flush kills a tag wherever it sits, including the head about to be registered as a response.
    for (genvar gi = 0; gi < NSTG; gi++) begin : g_tag_live
        assign tag_live[gi] = tag_v_reg[gi] & ~cancel[tag_id_reg[gi]];
    end

    // Stage 0 is loaded alongside the issue register; stage RD_LAT lines up with mem_rd_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v_reg <= '0;
            for (int s = 0; s < NSTG; s++) begin
                tag_id_reg[s] <= '0;
            end
        end else begin
            tag_v_reg[0]  <= grant_any;
            tag_id_reg[0] <= grant_id;
            for (int s = 1; s < NSTG; s++) begin
                tag_v_reg[s]  <= tag_live[s-1];
                tag_id_reg[s] <= tag_id_reg[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            if (tag_live[RD_LAT]) begin
                rd_valid <= N_CPUS'(1) << tag_id_reg[RD_LAT];
                rd_data  <= mem_rd_data;
            end else begin
                rd_valid <= '0;
            end
        end
    end

`ifdef PKTMEM_ARB_STATS_EN
    logic        conflict;
    logic [15:0] conflicts_reg;

    assign conflict = |(eligible & (eligible - N_CPUS'(1)));

    for (genvar gi = 0; gi < N_CPUS; gi++) begin : g_stat
        logic [15:0] cnt_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (grant[gi] && cnt_reg != 16'hFFFF) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
        assign stat_grants[gi*16 +: 16] = cnt_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflicts_reg <= '0;
        end else if (conflict && conflicts_reg != 16'hFFFF) begin
            conflicts_reg <= conflicts_reg + 16'd1;
        end
    end

    assign stat_conflicts = conflicts_reg;
`endif

endmodule

// File: tb/tb_pktmem_rd_arbiter.sv
// Scoreboard bench for pktmem_rd_arbiter: default instance (RD_LAT=1) plus an RD_LAT=3 instance for reset-in-flight.
module tb_pktmem_rd_arbiter;
    import pktmem_rd_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_b;
    logic [3:0]  rd_req, cancel, rd_ack, rd_valid;
    logic [3:0]  rd_req_b, cancel_b, rd_ack_b, rd_valid_b;
    logic [39:0] rd_addr;
    logic [7:0]  rd_sz;
    logic [31:0] rd_data, rd_data_b, mem_rd_data, mem_rd_data_b;
    logic        mem_rd_en, mem_rd_en_b;
    logic [9:0]  mem_rd_addr, mem_rd_addr_b;
    logic [1:0]  mem_rd_sz, mem_rd_sz_b;
`ifdef PKTMEM_ARB_STATS_EN
    logic [63:0] stat_grants, stat_grants_b;
    logic [15:0] stat_conflicts, stat_conflicts_b;
`endif

    logic [9:0]  addr_q [4];
    logic [1:0]  sz_q [4];
    assign rd_addr = {addr_q[3], addr_q[2], addr_q[1], addr_q[0]};
    assign rd_sz   = {sz_q[3], sz_q[2], sz_q[1], sz_q[0]};

    pktmem_rd_arbiter dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_sz(rd_sz),
        .cancel(cancel), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_sz(mem_rd_sz),
`ifdef PKTMEM_ARB_STATS_EN
        .stat_grants(stat_grants), .stat_conflicts(stat_conflicts),
`endif
        .mem_rd_data(mem_rd_data)
    );

    pktmem_rd_arbiter #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst_b), .rd_req(rd_req_b), .rd_addr(rd_addr), .rd_sz(rd_sz),
        .cancel(cancel_b), .rd_ack(rd_ack_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
        .mem_rd_en(mem_rd_en_b), .mem_rd_addr(mem_rd_addr_b), .mem_rd_sz(mem_rd_sz_b),
`ifdef PKTMEM_ARB_STATS_EN
        .stat_grants(stat_grants_b), .stat_conflicts(stat_conflicts_b),
`endif
        .mem_rd_data(mem_rd_data_b)
    );

    // Memory contents: a fixed pattern, with the one word the single-read test looks for.
    function automatic logic [31:0] mem_word(input logic [9:0] a);
        if (a == 10'h01C) return 32'hDEADBEEF;
        return {16'hA500, 6'b0, a};
    endfunction

    logic [9:0] apipe_a;
    logic [9:0] apipe_b [3];
    always @(posedge clk) begin
        apipe_a    <= mem_rd_addr;
        apipe_b[0] <= mem_rd_addr_b;
        apipe_b[1] <= apipe_b[0];
        apipe_b[2] <= apipe_b[1];
    end
    assign mem_rd_data   = mem_word(apipe_a);
    assign mem_rd_data_b = mem_word(apipe_b[2]);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h at cycle %0d", name, act, cyc);
        end
    endtask

    // Monitor: every rd_valid pulse of the default instance is matched against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid !== 4'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rd_valid %b expected none at cycle %0d", rd_valid, cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", 64'(rd_valid), 64'(e.v));
                chk("rsp_data", 64'(rd_data), 64'(e.d));
                chk("rsp_cycle", 64'(cyc), 64'(e.c));
            end
        end
    end

    // One cycle of stimulus: drive, check the combinational ack, record expected responses.
    task automatic step(input logic [3:0] req, input logic [3:0] can, input logic [3:0] exp_ack,
                        input string name);
        exp_t e;
        rd_req = req;
        cancel = can;
        for (int i = 0; i < 4; i++) begin
            if (can[i]) begin
                for (int j = sb.size() - 1; j >= 0; j--) begin
                    if (sb[j].v[i] && sb[j].c > cyc) sb.delete(j);
                end
            end
        end
        @(negedge clk);
        chk(name, 64'(rd_ack), 64'(exp_ack));
        for (int i = 0; i < 4; i++) begin
            if (exp_ack[i]) begin
                e.v = 4'(1) << i;
                e.d = mem_word(addr_q[i]);
                e.c = cyc + 3;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'b0000, 4'b0000, 4'b0000, "idle_ack");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] db;
        rst = 1'b1; rst_b = 1'b1;
        rd_req = 4'b1111; cancel = 4'b0000;
        rd_req_b = 4'b0000; cancel_b = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            addr_q[i] = 10'(10'h100 + i * 16);
            sz_q[i]   = 2'(i);
        end
        #1;

        // 1. reset with all cores requesting
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_ack", 64'(rd_ack), 64'h0);
            chk("rst_mem_en", 64'(mem_rd_en), 64'h0);
            chk("rst_valid", 64'(rd_valid), 64'h0);
            @(posedge clk);
            #1;
        end
        chk("rst_data", 64'(rd_data), 64'h0);
        chk("rst_mem_addr", 64'(mem_rd_addr), 64'h0);
        rst = 1'b0;
        step(4'b1111, 4'b0000, 4'b0001, "first_ack");
        idle(4);

        // 2. single read from core 2
        addr_q[2] = 10'h01C;
        step(4'b0100, 4'b0000, 4'b0100, "single_ack");
        chk("issue_en", 64'(mem_rd_en), 64'h1);
        chk("issue_addr", 64'(mem_rd_addr), 64'h01C);
        chk("issue_sz", 64'(mem_rd_sz), 64'h2);
        idle(4);
        chk("data_hold", 64'(rd_data), 64'hDEADBEEF);
        chk("idle_mem_en", 64'(mem_rd_en), 64'h0);

        // bring prio_ptr back to 0, then 3. fairness with all requesting
        step(4'b1000, 4'b0000, 4'b1000, "align_ack");
        for (int k = 0; k < 8; k++) step(4'b1111, 4'b0000, 4'(1) << (k % 4), "fair_ack");
        idle(4);

        // 4. cancel of an in-flight read
        step(4'b0010, 4'b0000, 4'b0010, "cxl_ack1");
        step(4'b1000, 4'b0010, 4'b1000, "cxl_ack3");
        idle(5);

        // 5. cancel and request on the same core
        step(4'b0011, 4'b0001, 4'b0010, "clash_ack");
        step(4'b0111, 4'b0000, 4'b0100, "ptr_after_clash");
        step(4'b0011, 4'b0000, 4'b0001, "wrap_ack");
        idle(4);

        // cancel in the response cycle keeps the already registered pulse
        step(4'b0001, 4'b0000, 4'b0001, "late_cxl_ack");
        idle(2);
        step(4'b0000, 4'b0001, 4'b0000, "late_cxl");
        idle(3);
        chk("sb_empty", 64'(sb.size()), 64'h0);

        // 6. RD_LAT=3 instance: normal read latency, then reset while a read is in flight
        rst_b = 1'b0;
        rd_req_b = 4'b0001;
        @(negedge clk);
        chk("b_ack", 64'(rd_ack_b), 64'h1);
        db = mem_word(addr_q[0]);
        @(posedge clk);
        #1;
        rd_req_b = 4'b0000;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("b_valid", 64'(rd_valid_b), (k == 5) ? 64'h1 : 64'h0);
            if (k == 5) chk("b_data", 64'(rd_data_b), 64'(db));
            @(posedge clk);
            #1;
        end
        rd_req_b = 4'b0010;
        @(negedge clk);
        chk("b_ack_mid", 64'(rd_ack_b), 64'h2);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        rd_req_b = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("b_rst_ack", 64'(rd_ack_b), 64'h0);
            chk("b_rst_mem_en", 64'(mem_rd_en_b), 64'h0);
`ifdef PKTMEM_ARB_STATS_EN
            chk("b_stat_grants", stat_grants_b, 64'h0);
            chk("b_stat_conflicts", 64'(stat_conflicts_b), 64'h0);
`endif
            @(posedge clk);
            #1;
        end
        rst_b = 1'b0;
        rd_req_b = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("b_no_stale", 64'(rd_valid_b), 64'h0);
        end
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
